instruction_decode: RTL and testbench
=====================================

// Module: instruction_decode
// PURPOSE
//  ID stage of the 5-stage RV32I pipeline; directly consumes IF_ID_IR/IF_ID_PC/IF_ID_PC4 from the fetch stage.
//  Decodes control, generates immediate, reads 32x32 register file (written back from WB), registers all into ID/EX.
//  Feeds the execute stage; exposes Rs1D/Rs2D to the hazard unit; FlushE inserts a bubble on taken branch/jump.
// PARAMETERS
//  XLEN      32  datapath width (only 32 supported)
//  NREGS     32  architectural registers; x0 hardwired to zero
// PORTS
//  clk          in   1   rising-edge clock
//  rst          in   1   asynchronous, active-low reset
//  IF_ID_IR     in   32  instruction from IF/ID
//  IF_ID_PC     in   32  PC of that instruction
//  IF_ID_PC4    in   32  PC+4 of that instruction
//  RegWriteW    in   1   WB write enable
//  RdW          in   5   WB destination register
//  ResultW      in   32  WB write data
//  FlushE       in   1   load bubble into ID/EX this edge
//  Rs1D, Rs2D   out  5   combinational source fields (IR[19:15], IR[24:20]) for hazard unit
//  RegWriteE    out  1   | ResultSrcE out 2 (00 ALU,01 mem,10 PC+4) | MemWriteE out 1
//  JumpE, BranchE out 1 each | ALUSrcE out 1 (1=imm) | ALUControlE out 4 | Funct3E out 3
//  RD1E, RD2E   out  32  register operands;  ImmExtE out 32 sign-extended immediate
//  RdE, Rs1E, Rs2E out 5; PCE, PCPlus4E out 32 registered copies
// BEHAVIOUR
//  - rst low (any time, async): every E-side output and every register-file entry -> 0; dominates FlushE.
//  - Latency: one cycle; decode on IF_ID_* in cycle N appears on *E outputs after edge N+1.
//  - FlushE=1 at an edge: all ID/EX fields -> 0 (NOP bubble; RegWriteE=MemWriteE=JumpE=BranchE=0).
//  - Immediate by opcode: I(0000011,0010011,1100111) {20{IR31},IR[31:20]}; S(0100011) {IR[31:25],IR[11:7]};
//    B(1100011) {IR31,IR7,IR[30:25],IR[11:8],0}; U(0110111,0010111) {IR[31:12],12'b0};
//    J(1101111) {IR31,IR[19:12],IR20,IR[30:21],0}; all sign-extended to 32.
//  - ALUControl: 0000 ADD,0001 SUB,0010 AND,0011 OR,0100 XOR,0101 SLL,0110 SRL,0111 SRA,1000 SLT,1001 SLTU,1010 PASSB.
//    R-type: funct7[5] selects SUB/SRA; I-type ignores funct7[5] except SRAI; loads/stores/JALR/AUIPC -> ADD;
//    LUI -> PASSB; branches -> SUB (EX uses Funct3E for condition).
//  - ALUSrc=1 for I, S, U, JALR; JAL: JumpE=1, ResultSrc=10; JALR: JumpE=1, ResultSrc=10, ALUSrc=1.
//  - Unknown opcode (incl. all-zero reset IR): all controls 0 (treated as NOP); fields still registered.
//  - Register file: write on rising clk when RegWriteW && RdW!=0; writes to x0 ignored; reads of x0 return 0.
//  - Same-cycle WB/read: if RegWriteW && RdW!=0 && RdW==Rs1D (Rs2D), RD1 (RD2) = ResultW (write-through bypass).
//  - Simultaneous FlushE and WB write: register write still occurs; only ID/EX is bubbled.
//  - Rs1E/Rs2E registered unconditionally from fields (zeroed only by flush/reset); U/J types carry garbage fields, harmless.
// STRUCTURE
//  - Shared package rv32i_pkg: opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
//    OP_LUI, OP_AUIPC), ALUControl encodings, ResultSrc encodings.
//  - Sub-module register_file (2 async read ports with write-through, 1 sync write port, async active-low clear).
//  - Control decode, immediate generation and ID/EX register live in this module.
// TESTING
//  1. rst low mid-run with valid IR -> all E outputs 0 immediately (before next edge); register file reads 0 after release.
//  2. IR=0x00500093 (addi x1,x0,5) -> next edge: RegWriteE=1, ALUSrcE=1, ALUControlE=0000, ImmExtE=5, RdE=1, RD1E=0.
//  3. WB RegWriteW=1,RdW=3,ResultW=0xDEADBEEF same cycle as IR=0x00318233 (add x4,x3,x3) -> RD1E=RD2E=0xDEADBEEF.
//  4. RegWriteW=1,RdW=0,ResultW=0x1234 then read x0 -> RD1E=0.
//  5. IR=0xFE0008E3 (beq x0,x0,-16) -> BranchE=1, ALUControlE=0001, ImmExtE=0xFFFFFFF0, Funct3E=000; same with FlushE=1 -> all 0.
//  6. IR=0x008000EF (jal x1,8) -> JumpE=1, ResultSrcE=10, ImmExtE=8, PCPlus4E=IF_ID_PC4; IR=0x123452B7 (lui) -> ImmExtE=0x12345000, ALUControlE=1010.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, ALU/result-select encodings, ID/EX payload layout.
package rv32i_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    AluAdd   = 4'b0000,
    AluSub   = 4'b0001,
    AluAnd   = 4'b0010,
    AluOr    = 4'b0011,
    AluXor   = 4'b0100,
    AluSll   = 4'b0101,
    AluSrl   = 4'b0110,
    AluSra   = 4'b0111,
    AluSlt   = 4'b1000,
    AluSltu  = 4'b1001,
    AluPassB = 4'b1010
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ResAlu = 2'b00,
    ResMem = 2'b01,
    ResPc4 = 2'b10
  } result_src_e;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic [3:0] alu_control;
  } ctrl_t;

  typedef struct packed {
    ctrl_t            ctrl;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  rd1;
    logic [XLEN-1:0]  rd2;
    logic [XLEN-1:0]  imm;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc4;
  } idex_t;

  // funct7[5] only distinguishes SUB for register-register ops; shifts use it for both forms.
  function automatic alu_ctrl_e alu_decode(input logic [2:0] f3, input logic f7b5,
                                           input logic is_r);
    alu_ctrl_e res;
    case (f3)
      3'b000: begin
        if (is_r && f7b5) res = AluSub;
        else              res = AluAdd;
      end
      3'b001: res = AluSll;
      3'b010: res = AluSlt;
      3'b011: res = AluSltu;
      3'b100: res = AluXor;
      3'b101: begin
        if (f7b5) res = AluSra;
        else      res = AluSrl;
      end
      3'b110: res = AluOr;
      default: res = AluAnd;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 register file: two async read ports with write-through, one sync write port, x0 = 0.
module register_file
  import rv32i_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      raddr1_i,
  input  logic [4:0]      raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic            wr_en;

  assign wr_en = we_i && (waddr_i != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[waddr_i] = wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Bypass the write-back value so ID sees it in the same cycle it is written.
  always_comb begin
    if (raddr1_i == 5'd0)                   rdata1_o = '0;
    else if (wr_en && waddr_i == raddr1_i)  rdata1_o = wdata_i;
    else                                    rdata1_o = regs_q[raddr1_i];
    if (raddr2_i == 5'd0)                   rdata2_o = '0;
    else if (wr_en && waddr_i == raddr2_i)  rdata2_o = wdata_i;
    else                                    rdata2_o = regs_q[raddr2_i];
  end

endmodule

// File: rtl/instruction_decode.sv
// RV32I ID stage: control decode, immediate generation, register read and the ID/EX register.
module instruction_decode
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IF_ID_IR,
  input  logic [31:0] IF_ID_PC,
  input  logic [31:0] IF_ID_PC4,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  input  logic        FlushE,
  output logic [4:0]  Rs1D,
  output logic [4:0]  Rs2D,
  output logic        RegWriteE,
  output logic [1:0]  ResultSrcE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        BranchE,
  output logic        ALUSrcE,
  output logic [3:0]  ALUControlE,
  output logic [2:0]  Funct3E,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [4:0]  RdE,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E
);

  logic [6:0]  opcode;
  logic [31:0] ir;
  logic [31:0] rd1, rd2, imm;
  ctrl_t       ctrl;
  idex_t       idex_d, idex_q;

  assign ir     = IF_ID_IR;
  assign opcode = ir[6:0];
  assign Rs1D   = ir[19:15];
  assign Rs2D   = ir[24:20];

  always_comb begin
    ctrl = '0;
    imm  = '0;
    case (opcode)
      OP_R: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_control = alu_decode(ir[14:12], ir[30], 1'b1);
      end
      OP_I: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = alu_decode(ir[14:12], ir[30], 1'b0);
        imm              = {{20{ir[31]}}, ir[31:20]};
      end
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = ResMem;
        imm             = {{20{ir[31]}}, ir[31:20]};
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm            = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      end
      OP_BRANCH: begin
        ctrl.branch      = 1'b1;
        ctrl.alu_control = AluSub;
        imm              = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
      end
      OP_JAL: begin
        ctrl.jump       = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = ResPc4;
        imm             = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
      end
      OP_JALR: begin
        ctrl.jump       = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = ResPc4;
        ctrl.alu_src    = 1'b1;
        imm             = {{20{ir[31]}}, ir[31:20]};
      end
      OP_LUI: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = AluPassB;
        imm              = {ir[31:12], 12'b0};
      end
      OP_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm            = {ir[31:12], 12'b0};
      end
      default: ;
    endcase
  end

  register_file u_register_file (
    .clk_i    (clk),
    .rst_ni   (rst),
    .we_i     (RegWriteW),
    .waddr_i  (RdW),
    .wdata_i  (ResultW),
    .raddr1_i (Rs1D),
    .raddr2_i (Rs2D),
    .rdata1_o (rd1),
    .rdata2_o (rd2)
  );

  always_comb begin
    idex_d = '0;
    if (!FlushE) begin
      idex_d.ctrl   = ctrl;
      idex_d.funct3 = ir[14:12];
      idex_d.rd1    = rd1;
      idex_d.rd2    = rd2;
      idex_d.imm    = imm;
      idex_d.rd     = ir[11:7];
      idex_d.rs1    = Rs1D;
      idex_d.rs2    = Rs2D;
      idex_d.pc     = IF_ID_PC;
      idex_d.pc4    = IF_ID_PC4;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idex_q <= '0;
    else      idex_q <= idex_d;
  end

  assign RegWriteE   = idex_q.ctrl.reg_write;
  assign ResultSrcE  = idex_q.ctrl.result_src;
  assign MemWriteE   = idex_q.ctrl.mem_write;
  assign JumpE       = idex_q.ctrl.jump;
  assign BranchE     = idex_q.ctrl.branch;
  assign ALUSrcE     = idex_q.ctrl.alu_src;
  assign ALUControlE = idex_q.ctrl.alu_control;
  assign Funct3E     = idex_q.funct3;
  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign ImmExtE     = idex_q.imm;
  assign RdE         = idex_q.rd;
  assign Rs1E        = idex_q.rs1;
  assign Rs2E        = idex_q.rs2;
  assign PCE         = idex_q.pc;
  assign PCPlus4E    = idex_q.pc4;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode with hand-computed expectations.
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IF_ID_IR, IF_ID_PC, IF_ID_PC4;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        FlushE;
  logic [4:0]  Rs1D, Rs2D;
  logic        RegWriteE;
  logic [1:0]  ResultSrcE;
  logic        MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [3:0]  ALUControlE;
  logic [2:0]  Funct3E;
  logic [31:0] RD1E, RD2E, ImmExtE;
  logic [4:0]  RdE, Rs1E, Rs2E;
  logic [31:0] PCE, PCPlus4E;

  int checks = 0;
  int errors = 0;

  instruction_decode dut (
    .clk         (clk),
    .rst         (rst),
    .IF_ID_IR    (IF_ID_IR),
    .IF_ID_PC    (IF_ID_PC),
    .IF_ID_PC4   (IF_ID_PC4),
    .RegWriteW   (RegWriteW),
    .RdW         (RdW),
    .ResultW     (ResultW),
    .FlushE      (FlushE),
    .Rs1D        (Rs1D),
    .Rs2D        (Rs2D),
    .RegWriteE   (RegWriteE),
    .ResultSrcE  (ResultSrcE),
    .MemWriteE   (MemWriteE),
    .JumpE       (JumpE),
    .BranchE     (BranchE),
    .ALUSrcE     (ALUSrcE),
    .ALUControlE (ALUControlE),
    .Funct3E     (Funct3E),
    .RD1E        (RD1E),
    .RD2E        (RD2E),
    .ImmExtE     (ImmExtE),
    .RdE         (RdE),
    .Rs1E        (Rs1E),
    .Rs2E        (Rs2E),
    .PCE         (PCE),
    .PCPlus4E    (PCPlus4E)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ir, input logic [31:0] pc);
    IF_ID_IR  = ir;
    IF_ID_PC  = pc;
    IF_ID_PC4 = pc + 32'd4;
  endtask

  initial begin
    rst = 1'b0;
    IF_ID_IR = '0; IF_ID_PC = '0; IF_ID_PC4 = '0;
    RegWriteW = 1'b0; RdW = '0; ResultW = '0; FlushE = 1'b0;
    #12;
    chk("reset_regwrite", 32'(RegWriteE), 32'd0);
    chk("reset_pc4", PCPlus4E, 32'd0);
    rst = 1'b1;

    // addi x1,x0,5
    issue(32'h00500093, 32'h100);
    step();
    chk("addi_regwrite", 32'(RegWriteE), 32'd1);
    chk("addi_alusrc", 32'(ALUSrcE), 32'd1);
    chk("addi_aluctl", 32'(ALUControlE), 32'h0);
    chk("addi_imm", ImmExtE, 32'd5);
    chk("addi_rd", 32'(RdE), 32'd1);
    chk("addi_rd1", RD1E, 32'd0);
    chk("addi_pc", PCE, 32'h100);
    chk("addi_pc4", PCPlus4E, 32'h104);

    // add x4,x3,x3 with x3 written back the same cycle
    issue(32'h00318233, 32'h104);
    RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'hDEADBEEF;
    #1;
    chk("add_rs1d", 32'(Rs1D), 32'd3);
    chk("add_rs2d", 32'(Rs2D), 32'd3);
    step();
    RegWriteW = 1'b0;
    chk("bypass_rd1", RD1E, 32'hDEADBEEF);
    chk("bypass_rd2", RD2E, 32'hDEADBEEF);
    chk("add_rd", 32'(RdE), 32'd4);
    chk("add_alusrc", 32'(ALUSrcE), 32'd0);
    step();
    chk("stored_rd1", RD1E, 32'hDEADBEEF);

    // write to x0 is ignored, read of x0 returns 0
    issue(32'h00000033, 32'h108);
    RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'h1234;
    step();
    chk("x0_bypass_rd1", RD1E, 32'd0);
    RegWriteW = 1'b0;
    step();
    chk("x0_stored_rd1", RD1E, 32'd0);

    // sub x2,x1,x2
    issue(32'h40208133, 32'h10C);
    step();
    chk("sub_aluctl", 32'(ALUControlE), 32'h1);

    // srai x5,x3,4
    issue(32'h4041D293, 32'h110);
    step();
    chk("srai_aluctl", 32'(ALUControlE), 32'h7);
    chk("srai_imm", ImmExtE, 32'h00000404);
    chk("srai_rd1", RD1E, 32'hDEADBEEF);

    // sw x3,-4(x0)
    issue(32'hFE302E23, 32'h114);
    step();
    chk("sw_memwrite", 32'(MemWriteE), 32'd1);
    chk("sw_regwrite", 32'(RegWriteE), 32'd0);
    chk("sw_imm", ImmExtE, 32'hFFFFFFFC);
    chk("sw_rd2", RD2E, 32'hDEADBEEF);
    chk("sw_alusrc", 32'(ALUSrcE), 32'd1);

    // lw x6,8(x3)
    issue(32'h0081A303, 32'h118);
    step();
    chk("lw_resultsrc", 32'(ResultSrcE), 32'h1);
    chk("lw_imm", ImmExtE, 32'd8);
    chk("lw_aluctl", 32'(ALUControlE), 32'h0);

    // beq x0,x0,-16
    issue(32'hFE0008E3, 32'h11C);
    step();
    chk("beq_branch", 32'(BranchE), 32'd1);
    chk("beq_aluctl", 32'(ALUControlE), 32'h1);
    chk("beq_imm", ImmExtE, 32'hFFFFFFF0);
    chk("beq_funct3", 32'(Funct3E), 32'h0);
    chk("beq_regwrite", 32'(RegWriteE), 32'd0);

    // same branch flushed, with a concurrent write-back to x7
    FlushE = 1'b1;
    RegWriteW = 1'b1; RdW = 5'd7; ResultW = 32'hCAFE0007;
    step();
    FlushE = 1'b0; RegWriteW = 1'b0;
    chk("flush_branch", 32'(BranchE), 32'd0);
    chk("flush_aluctl", 32'(ALUControlE), 32'h0);
    chk("flush_imm", ImmExtE, 32'd0);
    chk("flush_pc", PCE, 32'd0);

    // add x8,x7,x0 sees the write made during the flush
    issue(32'h00038433, 32'h120);
    step();
    chk("flush_wb_rd1", RD1E, 32'hCAFE0007);
    chk("flush_wb_rd", 32'(RdE), 32'd8);

    // lui x5,0x12345
    issue(32'h123452B7, 32'h124);
    step();
    chk("lui_imm", ImmExtE, 32'h12345000);
    chk("lui_aluctl", 32'(ALUControlE), 32'hA);
    chk("lui_rd", 32'(RdE), 32'd5);

    // jalr x1,0(x5)
    issue(32'h000280E7, 32'h128);
    step();
    chk("jalr_jump", 32'(JumpE), 32'd1);
    chk("jalr_alusrc", 32'(ALUSrcE), 32'd1);
    chk("jalr_resultsrc", 32'(ResultSrcE), 32'h2);

    // unknown opcode decodes as NOP but still registers fields
    issue(32'hFFFFFFFF, 32'h12C);
    step();
    chk("unk_regwrite", 32'(RegWriteE), 32'd0);
    chk("unk_imm", ImmExtE, 32'd0);
    chk("unk_funct3", 32'(Funct3E), 32'h7);
    chk("unk_rd", 32'(RdE), 32'd31);

    // jal x1,8
    issue(32'h008000EF, 32'h200);
    step();
    chk("jal_jump", 32'(JumpE), 32'd1);
    chk("jal_resultsrc", 32'(ResultSrcE), 32'h2);
    chk("jal_imm", ImmExtE, 32'd8);
    chk("jal_pc4", PCPlus4E, 32'h204);
    chk("jal_regwrite", 32'(RegWriteE), 32'd1);

    // asynchronous reset mid-cycle clears outputs before the next edge
    #2 rst = 1'b0;
    #1;
    chk("async_jump", 32'(JumpE), 32'd0);
    chk("async_pc4", PCPlus4E, 32'd0);
    chk("async_imm", ImmExtE, 32'd0);
    #1 rst = 1'b1;

    // register file cleared by reset
    issue(32'h00318233, 32'h300);
    step();
    chk("post_reset_rd1", RD1E, 32'd0);
    chk("post_reset_rd2", RD2E, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
